// File: rtl/fp32_add_sequencer.sv
// fp32_add_sequencer: control FSM for the FP32 add/sub datapath.
// Walks one operand pair through aligner -> mantissa adder -> normaliser,
// short-cutting special operands and oversized exponent gaps.
// Optional build macro: FP32_SEQ_WATCHDOG_EN (per-state timeout, sticky err).
module fp32_add_sequencer #(
    parameter int unsigned MAX_SHIFT = 25,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             busy,
    output logic             al_rst,
    output logic             al_en,
    output logic             al_load,
    output logic [22:0]      al_a,
    output logic [22:0]      al_b,
    output logic [7:0]       al_ea,
    output logic [7:0]       al_eb,
    input  logic             al_oe,
    output logic             add_start,
    input  logic             add_done,
    output logic             norm_start,
    input  logic             norm_done,
    output logic             bypass,
    output logic             big_sel,
    output logic             special,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state;
    logic [30:0] opa_q;
    logic [30:0] opb_q;
    logic        align_first;
    logic        wd_trip;

    logic [7:0]  ea_in;
    logic [7:0]  eb_in;
    logic [7:0]  d_in;
    logic        special_in;
    logic        bypass_in;

    // Aligner operands come straight from the captured pair, so they stay
    // stable for the whole transaction.
    assign al_a  = opa_q[22:0];
    assign al_b  = opb_q[22:0];
    assign al_ea = opa_q[30:23];
    assign al_eb = opb_q[30:23];

    // Classify the incoming pair while idle: exponent gap, specials, bypass.
    always_comb begin
        ea_in      = op_a[30:23];
        eb_in      = op_b[30:23];
        d_in       = (ea_in > eb_in) ? (ea_in - eb_in) : (eb_in - ea_in);
        special_in = (ea_in == 8'h00) || (ea_in == 8'hFF) ||
                     (eb_in == 8'h00) || (eb_in == 8'hFF);
        bypass_in  = 32'(d_in) > MAX_SHIFT;
    end

`ifdef FP32_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t          wd_prev;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_now;
    logic            err_q;

    // Cycles spent in the current state, including this one.
    always_comb begin
        wd_now  = (state != wd_prev) ? WD_W'(1) : (wd_cnt + WD_W'(1));
        wd_trip = ((state == ALIGN) || (state == ADD) ||
                   (state == NORM)  || (state == DONE)) &&
                  (wd_now == WD_W'(TIMEOUT));
    end

    // Track the previous state and the running per-state cycle count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_prev <= IDLE;
            wd_cnt  <= '0;
        end else begin
            wd_prev <= state;
            wd_cnt  <= wd_now;
        end
    end

    assign err = err_q;
`else
    assign wd_trip = 1'b0;
    assign err     = 1'b0;
`endif

    // Main sequencer: state and every control output are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            align_first <= 1'b0;
            busy        <= 1'b0;
            al_rst      <= 1'b1;
            al_en       <= 1'b0;
            al_load     <= 1'b0;
            add_start   <= 1'b0;
            norm_start  <= 1'b0;
            bypass      <= 1'b0;
            big_sel     <= 1'b0;
            special     <= 1'b0;
            shift_cnt   <= '0;
            res_valid   <= 1'b0;
`ifdef FP32_SEQ_WATCHDOG_EN
            err_q       <= 1'b0;
`endif
        end else begin
            al_load    <= 1'b0;
            add_start  <= 1'b0;
            norm_start <= 1'b0;
            if (abort || wd_trip) begin
                state     <= IDLE;
                busy      <= 1'b0;
                al_rst    <= 1'b1;
                al_en     <= 1'b0;
                res_valid <= 1'b0;
                special   <= 1'b0;
`ifdef FP32_SEQ_WATCHDOG_EN
                if (wd_trip) err_q <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opa_q     <= op_a[30:0];
                            opb_q     <= op_b[30:0];
                            shift_cnt <= '0;
                            busy      <= 1'b1;
                            al_rst    <= 1'b0;
                            if (special_in) begin
                                special   <= 1'b1;
                                bypass    <= 1'b0;
                                big_sel   <= 1'b0;
                                res_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                special <= 1'b0;
                                bypass  <= bypass_in;
                                big_sel <= bypass_in && (eb_in > ea_in);
                                al_en   <= 1'b1;
                                al_load <= 1'b1;
                                state   <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (bypass) begin
                            al_en     <= 1'b0;
                            add_start <= 1'b1;
                            state     <= ADD;
                        end else begin
                            align_first <= 1'b1;
                            state       <= ALIGN;
                        end
                    end
                    ALIGN: begin
                        align_first <= 1'b0;
                        if (shift_cnt != '1) shift_cnt <= shift_cnt + CNT_W'(1);
                        // al_oe still reflects the previous pair on the first cycle.
                        if (!align_first && al_oe) begin
                            al_en     <= 1'b0;
                            add_start <= 1'b1;
                            state     <= ADD;
                        end
                    end
                    ADD: begin
                        if (!add_start && add_done) begin
                            norm_start <= 1'b1;
                            state      <= NORM;
                        end
                    end
                    NORM: begin
                        if (!norm_start && norm_done) begin
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    DONE: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            special   <= 1'b0;
                            busy      <= 1'b0;
                            al_rst    <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
